branch_predict_resolve: RTL and testbench

BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

---
 rtl/branch_predict_resolve.sv | 79 +++++++
 tb/tb_branch_predict_resolve.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_predict_resolve.sv
// Branch prediction (2-bit BHT) in ID plus branch resolution and mispredict redirect in EXE,
// with saturating resolved/mispredicted branch statistics counters.
module branch_predict_resolve #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [31:0]      id_pc,
  input  logic             id_branch,
  output logic             id_btaken,
  input  logic [31:0]      epc,
  input  logic [31:0]      ebpc,
  input  logic             ebeq,
  input  logic             ebne,
  input  logic             ebtaken,
  input  logic             ezero,
  output logic             exe_flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  logic [Entries-1:0][1:0] bht_q, bht_d;
  logic [CNT_W-1:0]        branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]        mispred_cnt_q, mispred_cnt_d;

  logic [IDX_BITS-1:0] id_idx, ex_idx;
  logic                ebr, actual_taken;
  logic                unused_pc_bits;

  assign id_idx = id_pc[IDX_BITS+1:2];
  assign ex_idx = epc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{id_pc[31:IDX_BITS+2], id_pc[1:0]};

  // No bypass: ID sees the pre-update entry even when EXE writes the same index.
  assign id_btaken = id_branch & bht_q[id_idx][1];

  // ebeq wins when both decode bits are set.
  assign ebr          = ebeq | ebne;
  assign actual_taken = (ebeq & ezero) | (ebne & ~ebeq & ~ezero);
  assign exe_flush    = ebr & (actual_taken ^ ebtaken);
  assign redirect_pc  = actual_taken ? ebpc : (epc + 32'd4);

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  always_comb begin
    bht_d         = bht_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ebr) begin
      if (actual_taken) begin
        if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
      end
      if (branch_cnt_q != {CNT_W{1'b1}}) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (exe_flush && (mispred_cnt_q != {CNT_W{1'b1}})) begin
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < int'(Entries); i++) bht_q[i] <= 2'b01;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      bht_q         <= bht_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: prediction, resolution, BHT training and counters.
module tb_branch_predict_resolve;

  logic        clk;
  logic        clrn;
  logic [31:0] id_pc;
  logic        id_branch;
  logic        id_btaken;
  logic [31:0] epc;
  logic [31:0] ebpc;
  logic        ebeq;
  logic        ebne;
  logic        ebtaken;
  logic        ezero;
  logic        exe_flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_predict_resolve #(.IDX_BITS(4), .CNT_W(16)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .id_pc       (id_pc),
    .id_branch   (id_branch),
    .id_btaken   (id_btaken),
    .epc         (epc),
    .ebpc        (ebpc),
    .ebeq        (ebeq),
    .ebne        (ebne),
    .ebtaken     (ebtaken),
    .ezero       (ezero),
    .exe_flush   (exe_flush),
    .redirect_pc (redirect_pc),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, leaving time 1ns past it for driving and sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exe(input logic beq, input logic bne, input logic zero, input logic pred,
                         input logic [31:0] pc, input logic [31:0] bpc);
    ebeq = beq; ebne = bne; ezero = zero; ebtaken = pred; epc = pc; ebpc = bpc;
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; id_branch = 1'b1; id_pc = 32'h40;
    set_exe(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (id_btaken !== 1'b0) begin n_err++; $display("FAIL reset_btaken got %b want 0", id_btaken); end
    n_cmp++; if (branch_cnt !== 16'h0) begin n_err++; $display("FAIL reset_branch_cnt got %h want 0", branch_cnt); end
    n_cmp++; if (mispred_cnt !== 16'h0) begin n_err++; $display("FAIL reset_mispred_cnt got %h want 0", mispred_cnt); end
    // Flush stays combinational while held in reset.
    set_exe(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h80);
    n_cmp++; if (exe_flush !== 1'b1) begin n_err++; $display("FAIL reset_flush got %b want 1", exe_flush); end
    step();
    n_cmp++; if (branch_cnt !== 16'h0) begin n_err++; $display("FAIL reset_hold_cnt got %h want 0", branch_cnt); end
    set_exe(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 clrn = 1'b1;
    step();
  endtask

  task automatic test_mispredict();
    id_branch = 1'b1; id_pc = 32'h40;
    set_exe(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h80);
    n_cmp++; if (exe_flush !== 1'b1) begin n_err++; $display("FAIL mp_flush got %b want 1", exe_flush); end
    n_cmp++; if (redirect_pc !== 32'h80) begin n_err++; $display("FAIL mp_redirect got %h want 00000080", redirect_pc); end
    step();
    set_exe(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (id_btaken !== 1'b1) begin n_err++; $display("FAIL mp_bht0_weakT got %b want 1", id_btaken); end
    n_cmp++; if (mispred_cnt !== 16'd1) begin n_err++; $display("FAIL mp_mispred got %0d want 1", mispred_cnt); end
    n_cmp++; if (branch_cnt !== 16'd1) begin n_err++; $display("FAIL mp_branch got %0d want 1", branch_cnt); end
  endtask

  task automatic test_saturate();
    logic exp_bt [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    id_branch = 1'b1; id_pc = 32'h40;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_exe(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h80);
      else begin
        set_exe(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h80);
        n_cmp++; if (redirect_pc !== 32'h44) begin n_err++; $display("FAIL sat_nt_redirect[%0d] got %h want 00000044", i, redirect_pc); end
      end
      step();
      n_cmp++; if (id_btaken !== exp_bt[i]) begin n_err++; $display("FAIL sat_btaken[%0d] got %b want %b", i, id_btaken, exp_bt[i]); end
    end
    set_exe(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (branch_cnt !== 16'd7) begin n_err++; $display("FAIL sat_branch got %0d want 7", branch_cnt); end
    n_cmp++; if (mispred_cnt !== 16'd3) begin n_err++; $display("FAIL sat_mispred got %0d want 3", mispred_cnt); end
  endtask

  task automatic test_bne();
    set_exe(1'b0, 1'b1, 1'b0, 1'b1, 32'h1C, 32'h200);
    n_cmp++; if (exe_flush !== 1'b0) begin n_err++; $display("FAIL bne_flush got %b want 0", exe_flush); end
    n_cmp++; if (redirect_pc !== 32'h200) begin n_err++; $display("FAIL bne_redirect got %h want 00000200", redirect_pc); end
    step();
    set_exe(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (branch_cnt !== 16'd8) begin n_err++; $display("FAIL bne_branch got %0d want 8", branch_cnt); end
    n_cmp++; if (mispred_cnt !== 16'd3) begin n_err++; $display("FAIL bne_mispred got %0d want 3", mispred_cnt); end
  endtask

  task automatic test_both_and_wrap();
    // beq+bne together with a==b false: beq semantics, not taken.
    set_exe(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h300);
    n_cmp++; if (exe_flush !== 1'b1) begin n_err++; $display("FAIL both_flush got %b want 1", exe_flush); end
    n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL wrap_redirect got %h want 00000000", redirect_pc); end
    step();
    set_exe(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (mispred_cnt !== 16'd4) begin n_err++; $display("FAIL both_mispred got %0d want 4", mispred_cnt); end
  endtask

  task automatic test_no_branch();
    set_exe(1'b0, 1'b0, 1'b1, 1'b1, 32'h1C, 32'h500);
    n_cmp++; if (exe_flush !== 1'b0) begin n_err++; $display("FAIL nobr_flush got %b want 0", exe_flush); end
    step();
    n_cmp++; if (branch_cnt !== 16'd9) begin n_err++; $display("FAIL nobr_branch got %0d want 9", branch_cnt); end
    id_pc = 32'h1C; id_branch = 1'b0; #1;
    n_cmp++; if (id_btaken !== 1'b0) begin n_err++; $display("FAIL nobr_gate got %b want 0", id_btaken); end
    id_branch = 1'b1; #1;
    n_cmp++; if (id_btaken !== 1'b1) begin n_err++; $display("FAIL nobr_bht7 got %b want 1", id_btaken); end
  endtask

  task automatic test_same_cycle();
    id_branch = 1'b1; id_pc = 32'h44;
    set_exe(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h90);
    n_cmp++; if (id_btaken !== 1'b0) begin n_err++; $display("FAIL same_pre got %b want 0", id_btaken); end
    step();
    set_exe(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (id_btaken !== 1'b1) begin n_err++; $display("FAIL same_post got %b want 1", id_btaken); end
  endtask

  task automatic test_cnt_saturate_and_reset();
    // branch_cnt is 10 here; 65525 correctly predicted taken branches bring it to 0xFFFF.
    set_exe(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h100);
    for (int i = 0; i < 65525; i++) step();
    n_cmp++; if (branch_cnt !== 16'hFFFF) begin n_err++; $display("FAIL cnt_full got %h want ffff", branch_cnt); end
    step();
    n_cmp++; if (branch_cnt !== 16'hFFFF) begin n_err++; $display("FAIL cnt_sat got %h want ffff", branch_cnt); end
    n_cmp++; if (mispred_cnt !== 16'd5) begin n_err++; $display("FAIL cnt_mispred got %0d want 5", mispred_cnt); end
    id_branch = 1'b1; id_pc = 32'h80; #1;
    n_cmp++; if (id_btaken !== 1'b1) begin n_err++; $display("FAIL cnt_bht0 got %b want 1", id_btaken); end
    #1 clrn = 1'b0; #1;
    n_cmp++; if (branch_cnt !== 16'h0) begin n_err++; $display("FAIL async_branch got %h want 0", branch_cnt); end
    n_cmp++; if (mispred_cnt !== 16'h0) begin n_err++; $display("FAIL async_mispred got %h want 0", mispred_cnt); end
    n_cmp++; if (id_btaken !== 1'b0) begin n_err++; $display("FAIL async_bht got %b want 0", id_btaken); end
    step();
    n_cmp++; if (branch_cnt !== 16'h0) begin n_err++; $display("FAIL async_edge got %h want 0", branch_cnt); end
    #2 clrn = 1'b1;
    step();
    n_cmp++; if (branch_cnt !== 16'd1) begin n_err++; $display("FAIL first_edge got %0d want 1", branch_cnt); end
    n_cmp++; if (id_btaken !== 1'b1) begin n_err++; $display("FAIL first_edge_bht got %b want 1", id_btaken); end
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_saturate();
    test_bne();
    test_both_and_wrap();
    test_no_branch();
    test_same_cycle();
    test_cnt_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
